branch_check: RTL and testbench
===============================

Name: branch_check

Overview:
- Sits at the end of EX and closes the loop on the IF-side branch predictor.
- Compares each resolved control-flow instruction's predicted direction and target against the actual outcome.
- Issues a registered redirect to IF on a mispredict.
- Buffers predictor training updates (pc, taken, target) in a small FIFO and drains them one per cycle into the predictor's update port (pc_ex / ex_jump / ex_jump_plus / ex_jump_target).
- Keeps saturating branch and mispredict counters for performance debug.

Parameters:
- ADDR_W, 32, address and target width.
- DEPTH, 4, update FIFO entries; power of two, at least 2.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- rdy  in  1  global ready; when low, all state holds.
- ex_valid  in  1  EX holds a resolved control-flow instruction this cycle.
- ex_pc  in  ADDR_W  PC of that instruction.
- ex_taken  in  1  actual direction (1 for jal/jalr).
- ex_target  in  ADDR_W  actual taken target.
- ex_pred_taken  in  1  direction predicted at IF.
- ex_pred_target  in  ADDR_W  target predicted at IF.
- redirect_valid  out  1  one-cycle flush/redirect pulse to IF.
- redirect_pc  out  ADDR_W  correct next fetch PC.
- upd_valid  out  1  update available (drives predictor ex_jump).
- upd_ready  in  1  predictor accepts an update this cycle.
- upd_pc  out  ADDR_W  update PC (pc_ex).
- upd_taken  out  1  update direction (ex_jump_plus).
- upd_target  out  ADDR_W  update target (ex_jump_target).
- cnt_branch  out  CNT_W  resolved branches counted.
- cnt_mispred  out  CNT_W  mispredicts counted.
- upd_dropped  out  1  sticky flag: at least one update was lost to a full FIFO.

Behaviour:
- Reset (rst_n low, asynchronous):
  - redirect_valid=0, redirect_pc=0.
  - FIFO empty, so upd_valid=0; upd_pc, upd_target and upd_taken read 0.
  - Both counters 0; upd_dropped=0.
  - Reset mid-drain discards all queued updates.
- rdy low: no register changes, no pushes, no pops, and no counting. Outputs hold their values.
- Accepted instruction: acc = rdy & ex_valid & ~redirect_valid. Any ex_valid in the cycle a redirect is asserted is a wrong-path instruction and is ignored completely (no count, no push).
- Mispredict: mis = acc & ((ex_pred_taken != ex_taken) | (ex_taken & ex_pred_target != ex_target)). A not-taken outcome never compares targets.
- Redirect timing: one cycle after a mispredicted acc, redirect_valid=1 for exactly one cycle.
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4, computed modulo 2^ADDR_W, so 0xFFFFFFFC+4 = 0.
  - With no mispredict, redirect_valid=0 and redirect_pc holds its last value.
- Counters: cnt_branch increments on acc; cnt_mispred increments on mis. Both saturate at all ones and do not wrap.
- Update FIFO:
  - Every acc pushes {ex_pc, ex_taken, ex_target}, whether or not it mispredicted.
  - upd_* always present the head entry; upd_valid = ~empty.
  - Pop when rdy & upd_valid & upd_ready.
  - Push to an empty FIFO becomes visible on upd_* the next cycle (registered, no combinational bypass).
  - Push and pop in the same cycle are both performed; occupancy is unchanged, including when the FIFO is full.
  - Push while full with no pop: the new update is dropped, the FIFO is unchanged, and upd_dropped is set (sticky until reset).
  - Pointers are log2(DEPTH) bits and wrap naturally. A separate count register of log2(DEPTH)+1 bits distinguishes full from empty.
- Latency: ex -> redirect is 1 cycle; ex -> upd_valid is at least 1 cycle.

Decomposition:
- Shared package/config header:
  - ADDR_W default tied to the existing AddrLen.
  - Reset-value constants (ZERO_WORD).
  - Update-record field layout {pc, taken, target}, width ADDR_W*2+1.
- Sub-module upd_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, empty, full.
  - Gated by rdy and reset by rst_n.
- branch_check holds the compare logic, the redirect register and the counters.

Test Plan:
- Correct taken prediction: ex_pc=0x100, taken=1, target=0x200, pred 1/0x200, upd_ready=1.
  - Required: no redirect; next cycle upd_valid=1 with upd_pc=0x100, upd_taken=1, upd_target=0x200; cnt_branch=1, cnt_mispred=0.
- Direction mispredict: ex_pc=0x104, taken=0, pred_taken=1.
  - Required: next cycle redirect_valid=1 for exactly 1 cycle, redirect_pc=0x108; cnt_mispred=1.
  - Also: ex_pc=0xFFFFFFFC not-taken mispredict gives redirect_pc=0.
- Target mispredict and shadow: taken=1, target=0x300, pred_target=0x200.
  - Required: redirect_pc=0x300.
  - An ex_valid during the redirect cycle produces no push and no count.
- Backpressure and overflow (DEPTH=4): upd_ready=0, 6 accepted branches.
  - Required: FIFO holds the first 4 in order; upd_dropped=1.
  - Then upd_ready=1: pops 4 entries on 4 consecutive cycles in order, and upd_valid falls after the last.
- rdy gating: rdy=0 with ex_valid=1 and a mispredict presented.
  - Required: no redirect, no count, no pop; all outputs stable.
- Async reset mid-drain: rst_n low between clock edges with 3 entries queued and a redirect pending.
  - Required: immediately upd_valid=0, redirect_valid=0, counters=0.

Source files
------------

// File: rtl/branch_check_pkg.sv
// Shared configuration for the branch-check slice: default address width,
// reset constants and the update-record layout {pc, taken, target}.
package branch_check_pkg;

    localparam int unsigned ADDR_LEN = 32;
    localparam logic [ADDR_LEN-1:0] ZERO_WORD = '0;

    function automatic int unsigned upd_rec_width(input int unsigned addr_w);
        return 2 * addr_w + 1;
    endfunction

endpackage

// File: rtl/branch_check_if.sv
// EX-side resolve inputs, IF redirect, predictor update port and debug counters.
interface branch_check_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
);
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              upd_valid;
    logic              upd_ready;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic [CNT_W-1:0]  cnt_branch;
    logic [CNT_W-1:0]  cnt_mispred;
    logic              upd_dropped;

    modport master (
        output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output upd_ready,
        input  redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
        input  cnt_branch, cnt_mispred, upd_dropped
    );

    modport slave (
        input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  upd_ready,
        output redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
        output cnt_branch, cnt_mispred, upd_dropped
    );
endinterface

// File: rtl/branch_check_upd_fifo.sv
// Synchronous FIFO for predictor updates; registered output, no bypass,
// simultaneous push/pop allowed even when full.
module branch_check_upd_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = rdy & pop & ~empty;
    assign do_push = rdy & push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; dout is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_check.sv
// End-of-EX branch resolution: mispredict compare, registered IF redirect,
// predictor-update queue and saturating performance counters.
module branch_check
    import branch_check_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_LEN,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    branch_check_if.slave bus
);
    localparam int unsigned UPD_W = upd_rec_width(ADDR_W);

    logic              redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0]  cnt_mispred_q, cnt_mispred_d;
    logic              upd_dropped_q, upd_dropped_d;

    logic              acc, mis, pop_fire;
    logic              fifo_empty, fifo_full;
    logic [UPD_W-1:0]  fifo_din, fifo_dout;

    // Anything arriving while a redirect is out is wrong-path and ignored.
    assign acc = rdy & bus.ex_valid & ~redirect_valid_q;
    assign mis = acc & ((bus.ex_pred_taken != bus.ex_taken) |
                        (bus.ex_taken & (bus.ex_pred_target != bus.ex_target)));
    assign pop_fire = rdy & ~fifo_empty & bus.upd_ready;
    assign fifo_din = {bus.ex_pc, bus.ex_taken, bus.ex_target};

    branch_check_upd_fifo #(
        .WIDTH (UPD_W),
        .DEPTH (DEPTH)
    ) u_upd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .push  (acc),
        .pop   (bus.upd_ready),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        cnt_branch_d     = cnt_branch_q;
        cnt_mispred_d    = cnt_mispred_q;
        upd_dropped_d    = upd_dropped_q;
        if (rdy) redirect_valid_d = mis;
        if (mis) redirect_pc_d = bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_W'(4);
        if (acc && cnt_branch_q != '1) cnt_branch_d = cnt_branch_q + CNT_W'(1);
        if (mis && cnt_mispred_q != '1) cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
        if (acc && fifo_full && !pop_fire) upd_dropped_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= ADDR_W'(ZERO_WORD);
            cnt_branch_q     <= '0;
            cnt_mispred_q    <= '0;
            upd_dropped_q    <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            cnt_branch_q     <= cnt_branch_d;
            cnt_mispred_q    <= cnt_mispred_d;
            upd_dropped_q    <= upd_dropped_d;
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.cnt_branch     = cnt_branch_q;
    assign bus.cnt_mispred    = cnt_mispred_q;
    assign bus.upd_dropped    = upd_dropped_q;
    assign bus.upd_valid      = ~fifo_empty;
    assign {bus.upd_pc, bus.upd_taken, bus.upd_target} = fifo_dout;

endmodule

// File: tb/tb_branch_check.sv
// Self-checking bench for branch_check: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_branch_check;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 32;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    always #5 clk = ~clk;

    branch_check_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    branch_check #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    rec_t        q[$];
    logic        m_rv;
    logic [31:0] m_rpc;
    logic [31:0] m_cb, m_cm;
    logic        m_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rv = 1'b0; m_rpc = '0; m_cb = '0; m_cm = '0; m_drop = 1'b0;
    endtask

    // Applies one clock edge to the model using the inputs presented to the DUT.
    task automatic model_edge();
        bit acc, mis, pop, full;
        rec_t r;
        if (!rdy) return;
        acc  = bus.ex_valid && !m_rv;
        mis  = acc && ((bus.ex_pred_taken != bus.ex_taken) ||
                       (bus.ex_taken && bus.ex_pred_target != bus.ex_target));
        full = (q.size() == DEPTH);
        pop  = (q.size() > 0) && bus.upd_ready;
        if (pop) void'(q.pop_front());
        if (acc) begin
            r.pc = bus.ex_pc; r.taken = bus.ex_taken; r.target = bus.ex_target;
            if (!full || pop) q.push_back(r);
            else m_drop = 1'b1;
        end
        if (acc && m_cb != 32'hFFFF_FFFF) m_cb = m_cb + 1;
        if (mis && m_cm != 32'hFFFF_FFFF) m_cm = m_cm + 1;
        m_rv = mis;
        if (mis) m_rpc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
    endtask

    task automatic check_all(input string tag);
        rec_t h;
        h.pc = '0; h.taken = 1'b0; h.target = '0;
        if (q.size() > 0) h = q[0];
        check({tag, ".redirect_valid"}, 64'(bus.redirect_valid), 64'(m_rv));
        check({tag, ".redirect_pc"},    64'(bus.redirect_pc),    64'(m_rpc));
        check({tag, ".upd_valid"},      64'(bus.upd_valid),      64'(q.size() > 0));
        check({tag, ".upd_pc"},         64'(bus.upd_pc),         64'(h.pc));
        check({tag, ".upd_taken"},      64'(bus.upd_taken),      64'(h.taken));
        check({tag, ".upd_target"},     64'(bus.upd_target),     64'(h.target));
        check({tag, ".cnt_branch"},     64'(bus.cnt_branch),     64'(m_cb));
        check({tag, ".cnt_mispred"},    64'(bus.cnt_mispred),    64'(m_cm));
        check({tag, ".upd_dropped"},    64'(bus.upd_dropped),    64'(m_drop));
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bus.ex_valid = v; bus.ex_pc = pc; bus.ex_taken = tk; bus.ex_target = tgt;
        bus.ex_pred_taken = ptk; bus.ex_pred_target = ptgt;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        idle();
        bus.upd_ready = 1'b0;
        rdy = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        check("reset.upd_valid_const", 64'(bus.upd_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Correct taken prediction
        bus.upd_ready = 1'b1;
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        step("ok_taken");
        check("ok_taken.no_redirect", 64'(bus.redirect_valid), 64'd0);
        check("ok_taken.upd_pc_const", 64'(bus.upd_pc), 64'h100);
        check("ok_taken.upd_target_const", 64'(bus.upd_target), 64'h200);
        check("ok_taken.cnt_const", 64'(bus.cnt_branch), 64'd1);
        idle();
        step("ok_taken_pop");

        // Direction mispredict
        drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h500);
        step("dir_mis");
        check("dir_mis.redirect_pc_const", 64'(bus.redirect_pc), 64'h108);
        check("dir_mis.cnt_mispred_const", 64'(bus.cnt_mispred), 64'd1);
        idle();
        step("dir_mis_end");
        check("dir_mis.pulse_one_cycle", 64'(bus.redirect_valid), 64'd0);

        // Wrap of pc+4
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
        step("wrap");
        check("wrap.redirect_pc_const", 64'(bus.redirect_pc), 64'h0);
        idle();
        step("wrap_end");

        // Target mispredict followed by a wrong-path instruction
        drive(1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 32'h200);
        step("tgt_mis");
        check("tgt_mis.redirect_pc_const", 64'(bus.redirect_pc), 64'h300);
        drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h600);
        step("shadow");
        check("shadow.no_count", 64'(bus.cnt_branch), 64'd4);
        idle();
        for (int i = 0; i < 3; i++) step("drain");

        // Backpressure and overflow
        bus.upd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i), 1'b1, 32'h2000 + 32'(i));
            step("ovf_push");
        end
        check("ovf.dropped_const", 64'(bus.upd_dropped), 64'd1);
        idle();
        bus.upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf.order_pc", 64'(bus.upd_pc), 64'(32'h1000 + 32'(i * 4)));
            step("ovf_pop");
        end
        check("ovf.empty_after", 64'(bus.upd_valid), 64'd0);

        // rdy gating
        bus.upd_ready = 1'b0;
        drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0);
        step("gate_fill");
        rdy = 1'b0;
        bus.upd_ready = 1'b1;
        drive(1'b1, 32'h800, 1'b1, 32'h900, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step("gate_hold");
        check("gate.no_redirect", 64'(bus.redirect_valid), 64'd0);
        check("gate.no_pop", 64'(bus.upd_pc), 64'h700);
        rdy = 1'b1;
        idle();
        step("gate_release");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            logic        tk;
            tk  = 1'($urandom_range(0, 1));
            tgt = 32'h100 * 32'($urandom_range(1, 3));
            drive(1'($urandom_range(0, 3) != 0), {$urandom} & 32'hFFFF_FFFC, tk, tgt,
                  ($urandom_range(0, 3) == 0) ? ~tk : tk,
                  ($urandom_range(0, 3) == 0) ? tgt + 32'h100 : tgt);
            bus.upd_ready = 1'($urandom_range(0, 2) != 0);
            rdy = 1'($urandom_range(0, 9) != 0);
            step("rand");
        end
        rdy = 1'b1;

        // Async reset mid-drain with a redirect pending
        bus.upd_ready = 1'b1;
        idle();
        for (int i = 0; i < 6; i++) step("pre_rst_drain");
        bus.upd_ready = 1'b0;
        drive(1'b1, 32'hA00, 1'b1, 32'hB00, 1'b1, 32'hB00);
        step("rst_fill");
        drive(1'b1, 32'hA04, 1'b0, 32'h0, 1'b0, 32'h0);
        step("rst_fill");
        drive(1'b1, 32'hA08, 1'b1, 32'hC00, 1'b0, 32'h0);
        step("rst_fill");
        check("rst.redirect_pending", 64'(bus.redirect_valid), 64'd1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.upd_valid", 64'(bus.upd_valid), 64'd0);
        check("rst.redirect_valid", 64'(bus.redirect_valid), 64'd0);
        check("rst.cnt_branch", 64'(bus.cnt_branch), 64'd0);
        check("rst.cnt_mispred", 64'(bus.cnt_mispred), 64'd0);
        check_all("rst_async");
        #1 rst_n = 1'b1;
        bus.upd_ready = 1'b1;
        step("post_rst");
        drive(1'b1, 32'hD00, 1'b1, 32'hE00, 1'b1, 32'hE00);
        step("post_rst_push");
        idle();
        step("post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
